// File: rtl/alu_seq.sv
// alu_seq: WIDTH-bit sequential ALU, single-cycle logic/add/sub plus iterative shift-add MUL and restoring DIV
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] rem,
    output logic             cf,
    output logic             zf,
    output logic             vf,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] hi, lo, b_q, hi_n, lo_n, r_c, rem_c;
    logic [WIDTH:0]   sum, diff, mul_sum, div_sh;
    logic [WIDTH+1:0] div_df;
    logic [CW-1:0]    cnt;
    logic             is_mul, accept, iterative, last, cf_c, vf_c;

    assign accept    = start && state != ITER;
    assign iterative = op == 3'b110 || (op == 3'b111 && b != '0);
    assign last      = cnt == CW'(WIDTH - 1);
    assign busy      = state == ITER;
    assign done      = state == DONE;

    // single-cycle results, including the divide-by-zero shortcut
    always_comb begin
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        r_c   = '0;
        rem_c = '0;
        cf_c  = 1'b0;
        vf_c  = 1'b0;
        case (op)
            3'b000: begin
                r_c  = sum[WIDTH-1:0];
                cf_c = sum[WIDTH];
                vf_c = a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1];
            end
            3'b001: begin
                r_c  = diff[WIDTH-1:0];
                cf_c = diff[WIDTH];
                vf_c = a[WIDTH-1] != b[WIDTH-1] && diff[WIDTH-1] != a[WIDTH-1];
            end
            3'b010: r_c = a & b;
            3'b011: r_c = a | b;
            3'b100: r_c = a ^ b;
            3'b101: r_c = ~a;
            3'b111: begin
                r_c   = '1;
                rem_c = a;
                cf_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // one iteration step: hi/lo hold product halves for MUL, remainder/quotient for DIV
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi, lo[WIDTH-1]};
        div_df  = {1'b0, div_sh} - {2'b00, b_q};
        hi_n    = is_mul ? mul_sum[WIDTH:1] : (div_df[WIDTH+1] ? div_sh[WIDTH-1:0] : div_df[WIDTH-1:0]);
        lo_n    = is_mul ? {mul_sum[0], lo[WIDTH-1:1]} : {lo[WIDTH-2:0], ~div_df[WIDTH+1]};
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state; DONE accepts a new start just like IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = accept ? (iterative ? ITER : DONE) : IDLE;
            ITER:       state_n = last ? DONE : ITER;
            default:    state_n = IDLE;
        endcase
    end

    // datapath: latch operands, iterate, and register results/flags on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r      <= '0;
            rem    <= '0;
            cf     <= 1'b0;
            zf     <= 1'b0;
            vf     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            b_q    <= '0;
            cnt    <= '0;
            is_mul <= 1'b0;
        end else if (accept && iterative) begin
            hi     <= '0;
            lo     <= a;
            b_q    <= b;
            cnt    <= '0;
            is_mul <= op == 3'b110;
        end else if (accept) begin
            r   <= r_c;
            rem <= rem_c;
            cf  <= cf_c;
            zf  <= r_c == '0;
            vf  <= vf_c;
        end else if (state == ITER) begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt + 1'b1;
            if (last) begin
                r   <= lo_n;
                rem <= hi_n;
                cf  <= is_mul && hi_n != '0;
                zf  <= lo_n == '0;
                vf  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: vector table, random ops against an arithmetic model, and handshake corner cases
module tb_alu_seq;
    logic       clk = 1'b0, rst = 1'b1, start4 = 1'b0, start8 = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'd0, b = 8'd0;
    logic [3:0] r4, rem4;
    logic [7:0] r8, rem8;
    logic       cf4, zf4, vf4, busy4, done4, cf8, zf8, vf8, busy8, done8;
    int         n_chk = 0, n_fail = 0;

    typedef struct {
        int         w;
        logic [2:0] op;
        logic [7:0] a, b, r, rem;
        logic [2:0] f;
        int         lat;
    } vec_t;
    vec_t tv[15];

    alu_seq #(.WIDTH(4)) d4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a[3:0]), .b(b[3:0]),
        .r(r4), .rem(rem4), .cf(cf4), .zf(zf4), .vf(vf4), .busy(busy4), .done(done4)
    );
    alu_seq #(.WIDTH(8)) d8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .a(a), .b(b),
        .r(r8), .rem(rem8), .cf(cf8), .zf(zf8), .vf(vf8), .busy(busy8), .done(done8)
    );

    always #5 clk = ~clk;

    // busy and done must never be seen together
    always @(negedge clk) begin
        if (!rst) begin
            n_chk++;
            if ((busy4 && done4) || (busy8 && done8)) begin
                n_fail++;
                $display("FAIL busy_done_overlap: busy4=%0b done4=%0b busy8=%0b done8=%0b", busy4, done4, busy8, done8);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic smp(input int w, output logic [7:0] rr, output logic [7:0] rm,
                       output logic [2:0] f, output logic bz, output logic dn);
        if (w == 4) begin
            rr = {4'h0, r4}; rm = {4'h0, rem4}; f = {cf4, zf4, vf4}; bz = busy4; dn = done4;
        end else begin
            rr = r8; rm = rem8; f = {cf8, zf8, vf8}; bz = busy8; dn = done8;
        end
    endtask

    function automatic void model(input int w, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                                  output logic [7:0] er, output logic [7:0] erem, output logic [2:0] ef,
                                  output int lat);
        longint one, m, half, ua, ub, sa, sb, s, res, hi;
        logic c, v;
        one = 1; m = (one << w) - 1; half = one << (w - 1);
        ua = longint'(x) & m; ub = longint'(y) & m;
        sa = ua >= half ? ua - (one << w) : ua;
        sb = ub >= half ? ub - (one << w) : ub;
        hi = 0; c = 1'b0; v = 1'b0; lat = 1; res = 0;
        case (o)
            3'd0: begin res = ua + ub; c = res > m; s = sa + sb; v = s < -half || s >= half; end
            3'd1: begin res = ua - ub; c = ua < ub; s = sa - sb; v = s < -half || s >= half; end
            3'd2: res = ua & ub;
            3'd3: res = ua | ub;
            3'd4: res = ua ^ ub;
            3'd5: res = ~ua;
            3'd6: begin res = ua * ub; hi = res >> w; c = hi != 0; lat = w + 1; end
            default: begin
                if (ub == 0) begin res = m; hi = ua; c = 1'b1; end
                else begin res = ua / ub; hi = ua % ub; lat = w + 1; end
            end
        endcase
        res = res & m;
        er = res[7:0]; erem = hi[7:0]; ef = {c, res == 0, v};
    endfunction

    task automatic run(input int w, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] er, input logic [7:0] erem, input logic [2:0] ef,
                       input int lat, input string nm);
        logic [7:0] rr, rm;
        logic [2:0] f;
        logic bz, dn;
        int edges, bc;
        @(negedge clk);
        op = o; a = x; b = y; start4 = w == 4; start8 = w == 8;
        @(negedge clk);
        start4 = 1'b0; start8 = 1'b0; edges = 1; bc = 0;
        smp(w, rr, rm, f, bz, dn);
        while (!dn && edges < 40) begin
            if (bz) bc++;
            @(negedge clk);
            edges++;
            smp(w, rr, rm, f, bz, dn);
        end
        chk({nm, " latency"}, 64'(edges), 64'(lat));
        chk({nm, " r"}, 64'(rr), 64'(er));
        chk({nm, " rem"}, 64'(rm), 64'(erem));
        chk({nm, " cf_zf_vf"}, 64'(f), 64'(ef));
        chk({nm, " busy_cycles"}, 64'(bc), 64'(lat - 1));
        @(negedge clk);
        smp(w, rr, rm, f, bz, dn);
        chk({nm, " done_pulse"}, 64'(dn), 64'(0));
        chk({nm, " r_hold"}, 64'(rr), 64'(er));
    endtask

    initial begin
        logic [7:0] er, erem, rr, rm, x, y;
        logic [2:0] ef, o;
        int lat, w, edges, dones, de;

        tv[0]  = '{4, 3'd0, 8'h04, 8'h03, 8'h07, 8'h00, 3'b000, 1};
        tv[1]  = '{4, 3'd0, 8'h0F, 8'h0F, 8'h0E, 8'h00, 3'b100, 1};
        tv[2]  = '{4, 3'd1, 8'h08, 8'h02, 8'h06, 8'h00, 3'b001, 1};
        tv[3]  = '{4, 3'd1, 8'h02, 8'h08, 8'h0A, 8'h00, 3'b101, 1};
        tv[4]  = '{4, 3'd2, 8'h07, 8'h05, 8'h05, 8'h00, 3'b000, 1};
        tv[5]  = '{4, 3'd3, 8'h06, 8'h09, 8'h0F, 8'h00, 3'b000, 1};
        tv[6]  = '{8, 3'd6, 8'd200, 8'd3, 8'h58, 8'h02, 3'b100, 9};
        tv[7]  = '{8, 3'd6, 8'd15, 8'd17, 8'hFF, 8'h00, 3'b000, 9};
        tv[8]  = '{8, 3'd7, 8'd100, 8'd7, 8'd14, 8'd2, 3'b000, 9};
        tv[9]  = '{8, 3'd7, 8'd5, 8'd0, 8'hFF, 8'd5, 3'b100, 1};
        tv[10] = '{8, 3'd7, 8'd0, 8'd9, 8'h00, 8'h00, 3'b010, 9};
        tv[11] = '{8, 3'd4, 8'hF0, 8'hFF, 8'h0F, 8'h00, 3'b000, 1};
        tv[12] = '{8, 3'd5, 8'h5A, 8'h33, 8'hA5, 8'h00, 3'b000, 1};
        tv[13] = '{4, 3'd0, 8'h08, 8'h08, 8'h00, 8'h00, 3'b111, 1};
        tv[14] = '{8, 3'd0, 8'h7F, 8'h01, 8'h80, 8'h00, 3'b001, 1};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset w4", 64'({r4, rem4, cf4, zf4, vf4, busy4, done4}), 64'(0));
        chk("reset w8", 64'({r8, rem8, cf8, zf8, vf8, busy8, done8}), 64'(0));

        for (int i = 0; i < 15; i++)
            run(tv[i].w, tv[i].op, tv[i].a, tv[i].b, tv[i].r, tv[i].rem, tv[i].f, tv[i].lat, $sformatf("vec%0d", i));

        for (int i = 0; i < 60; i++) begin
            w = $urandom_range(1) == 1 ? 8 : 4;
            o = 3'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (w == 4) begin x = x & 8'h0F; y = y & 8'h0F; end
            if ($urandom_range(7) == 0) y = 8'h00;
            model(w, o, x, y, er, erem, ef, lat);
            run(w, o, x, y, er, erem, ef, lat, $sformatf("rnd%0d w%0d op%0d", i, w, o));
        end

        @(negedge clk);
        op = 3'd6; a = 8'd200; b = 8'd3; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; edges = 1;
        repeat (2) @(negedge clk);
        edges += 2;
        op = 3'd0; a = 8'd1; b = 8'd1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; edges++; dones = 0; de = 0; rr = 8'h00; rm = 8'h00; ef = 3'b000;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                dones++;
                if (de == 0) begin de = edges; rr = r8; rm = rem8; ef = {cf8, zf8, vf8}; end
            end
            @(negedge clk);
            edges++;
        end
        chk("midmul done_count", 64'(dones), 64'(1));
        chk("midmul latency", 64'(de), 64'(9));
        chk("midmul r", 64'(rr), 64'(8'h58));
        chk("midmul rem", 64'(rm), 64'(8'h02));
        chk("midmul flags", 64'(ef), 64'(3'b100));

        op = 3'd0; a = 8'd1; b = 8'd2; start8 = 1'b1;
        @(negedge clk);
        chk("b2b first done", 64'(done8), 64'(1));
        chk("b2b first r", 64'(r8), 64'(8'd3));
        op = 3'd1; a = 8'd5; b = 8'd7;
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b second done", 64'(done8), 64'(1));
        chk("b2b second r", 64'(r8), 64'(8'hFE));
        chk("b2b second flags", 64'({cf8, zf8, vf8}), 64'(3'b100));
        @(negedge clk);
        chk("b2b done_drop", 64'(done8), 64'(0));

        op = 3'd7; a = 8'd100; b = 8'd7; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst middiv outputs", 64'({r8, rem8, cf8, zf8, vf8, busy8, done8}), 64'(0));
        rst = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (done8) dones++;
        end
        chk("rst middiv no_done", 64'(dones), 64'(0));
        run(8, 3'd0, 8'h10, 8'h20, 8'h30, 8'h00, 3'b000, 1, "post_rst add");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
